// File: rtl/router_pkg.sv
// router_pkg
//   Shared definitions for the deflection router permutation stage.
//   Flit layout: [10] golden, [9] silver, [8:6] age, [5:3] dest x, [2:0] dest y.
//   Contents:
//     flit_t      - one flit
//     port_e      - output port identifiers (N=0, S=1, E=2, W=3)
//     arb_kind_e  - steering rule used by a 2x2 arbiter block
//     prod_port() - productive output port of a flit at a given router
//     age_inc()   - saturating age increment applied on traversal
package router_pkg;

  localparam int FW      = 11;
  localparam int GOLD_B  = 10;
  localparam int SILV_B  = 9;
  localparam int AGE_MSB = 8;
  localparam int AGE_LSB = 6;
  localparam int DX_MSB  = 5;
  localparam int DX_LSB  = 3;
  localparam int DY_MSB  = 2;
  localparam int DY_LSB  = 0;

  typedef logic [FW-1:0] flit_t;

  typedef enum logic [1:0] {
    PORT_N = 2'd0,
    PORT_S = 2'd1,
    PORT_E = 2'd2,
    PORT_W = 2'd3
  } port_e;

  // ARB_STAGE1 sends the winner to o0 (block C) when it wants N/S, else o1 (block D).
  // ARB_PAIR_NS / ARB_PAIR_EW are the final blocks: o0 is the first port of the pair.
  typedef enum logic [1:0] {
    ARB_STAGE1  = 2'd0,
    ARB_PAIR_NS = 2'd1,
    ARB_PAIR_EW = 2'd2
  } arb_kind_e;

  // X is resolved before Y; a flit already at its destination maps to N.
  function automatic port_e prod_port(input flit_t f, input logic [2:0] myX, input logic [2:0] myY);
    logic [2:0] dx;
    logic [2:0] dy;
    dx = f[DX_MSB:DX_LSB];
    dy = f[DY_MSB:DY_LSB];
    if (dx > myX)      prod_port = PORT_E;
    else if (dx < myX) prod_port = PORT_W;
    else if (dy > myY) prod_port = PORT_N;
    else if (dy < myY) prod_port = PORT_S;
    else               prod_port = PORT_N;
  endfunction

  function automatic flit_t age_inc(input flit_t f);
    flit_t r;
    r = f;
    if (f[AGE_MSB:AGE_LSB] != 3'd7) r[AGE_MSB:AGE_LSB] = f[AGE_MSB:AGE_LSB] + 3'd1;
    return r;
  endfunction

endpackage

// File: rtl/perm_arb2x2.sv
// perm_arb2x2
//   One 2x2 block of the permutation network. Picks a winner between two
//   flits by priority (valid, golden, silver, age), breaks full ties with a
//   per-block toggle, and steers the winner toward its productive side.
//   Ports:
//     clk, rst_n     - clock, async active-low reset (clears the toggle)
//     a_i/av_i       - upper input flit and valid
//     b_i/bv_i       - lower input flit and valid
//     o0_o/ov0_o     - first output flit and valid
//     o1_o/ov1_o     - second output flit and valid
module perm_arb2x2 import router_pkg::*; #(
  parameter arb_kind_e  KIND = ARB_STAGE1,
  parameter logic [2:0] MY_X = 3'd0,
  parameter logic [2:0] MY_Y = 3'd0
) (
  input  logic  clk,
  input  logic  rst_n,
  input  flit_t a_i,
  input  logic  av_i,
  input  flit_t b_i,
  input  logic  bv_i,
  output flit_t o0_o,
  output logic  ov0_o,
  output flit_t o1_o,
  output logic  ov1_o
);

  logic toggle_q, toggle_d;
  logic [5:0] keyA, keyB;
  logic tie, aWins, toHigh;
  flit_t winF, loseF;
  logic winV, loseV;
  port_e winPort;

  // Priority key: the valid bit on top makes a lone valid flit always win;
  // the rest ranks golden, then silver, then age.
  always_comb begin
    keyA  = {av_i, a_i[GOLD_B], a_i[SILV_B], a_i[AGE_MSB:AGE_LSB]};
    keyB  = {bv_i, b_i[GOLD_B], b_i[SILV_B], b_i[AGE_MSB:AGE_LSB]};
    tie   = av_i && bv_i && (keyA == keyB);
    aWins = (keyA > keyB) || ((keyA == keyB) && !toggle_q);
    toggle_d = toggle_q ^ tie;

    winF  = aWins ? a_i  : b_i;
    winV  = aWins ? av_i : bv_i;
    loseF = aWins ? b_i  : a_i;
    loseV = aWins ? bv_i : av_i;

    winPort = prod_port(winF, MY_X, MY_Y);
    if (KIND == ARB_STAGE1)       toHigh = !((winPort == PORT_N) || (winPort == PORT_S));
    else if (KIND == ARB_PAIR_NS) toHigh = (winPort == PORT_S);
    else                          toHigh = (winPort == PORT_W);

    o0_o  = toHigh ? loseF : winF;
    ov0_o = toHigh ? loseV : winV;
    o1_o  = toHigh ? winF  : loseF;
    ov1_o = toHigh ? winV  : loseV;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) toggle_q <= 1'b0;
    else        toggle_q <= toggle_d;
  end

endmodule

// File: rtl/permute_stage.sv
// permute_stage
//   Pipeline stage 2 of the bufferless deflection router. Registers the four
//   incoming flits, routes them through a two-level network of 2x2 arbiters
//   and registers the result, so every valid flit leaves on exactly one port
//   two edges after it was presented.
//   Ports:
//     clk, rst_n        - clock, async active-low reset
//     in_n/s/e/w        - input flits, iv_n/s/e/w their valids
//     out_n/s/e/w       - output flits (zero when invalid), ov_n/s/e/w valids
//     defl_cnt          - saturating count of deflected flits
//   Configuration macro: PERM_STATS_EN enables the deflection counter;
//   without it defl_cnt is tied to zero.
module permute_stage import router_pkg::*; #(
  parameter logic [2:0] MY_X = 3'd0,
  parameter logic [2:0] MY_Y = 3'd0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [FW-1:0] in_n,
  input  logic [FW-1:0] in_s,
  input  logic [FW-1:0] in_e,
  input  logic [FW-1:0] in_w,
  input  logic          iv_n,
  input  logic          iv_s,
  input  logic          iv_e,
  input  logic          iv_w,
  output logic [FW-1:0] out_n,
  output logic [FW-1:0] out_s,
  output logic [FW-1:0] out_e,
  output logic [FW-1:0] out_w,
  output logic          ov_n,
  output logic          ov_s,
  output logic          ov_e,
  output logic          ov_w,
  output logic [15:0]   defl_cnt
);

  flit_t inFlit_q [4];
  logic [3:0] inValid_q;
  flit_t aO0, aO1, bO0, bO1;
  logic aV0, aV1, bV0, bV1;
  flit_t netFlit [4];
  logic [3:0] netValid;
  flit_t outFlit_d [4];
  flit_t outFlit_q [4];
  logic [3:0] outValid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < 4; p++) inFlit_q[p] <= '0;
      inValid_q <= '0;
    end else begin
      inFlit_q[PORT_N] <= in_n;
      inFlit_q[PORT_S] <= in_s;
      inFlit_q[PORT_E] <= in_e;
      inFlit_q[PORT_W] <= in_w;
      inValid_q <= {iv_w, iv_e, iv_s, iv_n};
    end
  end

  // Stage 1: A = {N,E}, B = {S,W}. Output 0 of each feeds C, output 1 feeds D.
  perm_arb2x2 #(.KIND(ARB_STAGE1), .MY_X(MY_X), .MY_Y(MY_Y)) uArbA (
    .clk(clk), .rst_n(rst_n),
    .a_i(inFlit_q[PORT_N]), .av_i(inValid_q[PORT_N]),
    .b_i(inFlit_q[PORT_E]), .bv_i(inValid_q[PORT_E]),
    .o0_o(aO0), .ov0_o(aV0), .o1_o(aO1), .ov1_o(aV1)
  );

  perm_arb2x2 #(.KIND(ARB_STAGE1), .MY_X(MY_X), .MY_Y(MY_Y)) uArbB (
    .clk(clk), .rst_n(rst_n),
    .a_i(inFlit_q[PORT_S]), .av_i(inValid_q[PORT_S]),
    .b_i(inFlit_q[PORT_W]), .bv_i(inValid_q[PORT_W]),
    .o0_o(bO0), .ov0_o(bV0), .o1_o(bO1), .ov1_o(bV1)
  );

  // Stage 2: C drives {N,S}, D drives {E,W}.
  perm_arb2x2 #(.KIND(ARB_PAIR_NS), .MY_X(MY_X), .MY_Y(MY_Y)) uArbC (
    .clk(clk), .rst_n(rst_n),
    .a_i(aO0), .av_i(aV0), .b_i(bO0), .bv_i(bV0),
    .o0_o(netFlit[PORT_N]), .ov0_o(netValid[PORT_N]),
    .o1_o(netFlit[PORT_S]), .ov1_o(netValid[PORT_S])
  );

  perm_arb2x2 #(.KIND(ARB_PAIR_EW), .MY_X(MY_X), .MY_Y(MY_Y)) uArbD (
    .clk(clk), .rst_n(rst_n),
    .a_i(aO1), .av_i(aV1), .b_i(bO1), .bv_i(bV1),
    .o0_o(netFlit[PORT_E]), .ov0_o(netValid[PORT_E]),
    .o1_o(netFlit[PORT_W]), .ov1_o(netValid[PORT_W])
  );

  // Invalid slots are forced to zero so the links never see stale data.
  always_comb begin
    for (int p = 0; p < 4; p++) outFlit_d[p] = netValid[p] ? age_inc(netFlit[p]) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < 4; p++) outFlit_q[p] <= '0;
      outValid_q <= '0;
    end else begin
      for (int p = 0; p < 4; p++) outFlit_q[p] <= outFlit_d[p];
      outValid_q <= netValid;
    end
  end

  assign out_n = outFlit_q[PORT_N];
  assign out_s = outFlit_q[PORT_S];
  assign out_e = outFlit_q[PORT_E];
  assign out_w = outFlit_q[PORT_W];
  assign ov_n  = outValid_q[PORT_N];
  assign ov_s  = outValid_q[PORT_S];
  assign ov_e  = outValid_q[PORT_E];
  assign ov_w  = outValid_q[PORT_W];

`ifdef PERM_STATS_EN
  logic [2:0]  deflNum;
  logic [16:0] deflSum;
  logic [15:0] deflCnt_q, deflCnt_d;

  // Counts flits landing on a port other than their productive one, in the
  // same cycle they are registered onto the outputs.
  always_comb begin
    deflNum = '0;
    for (int p = 0; p < 4; p++) begin
      if (netValid[p] && (prod_port(netFlit[p], MY_X, MY_Y) != port_e'(p[1:0])))
        deflNum = deflNum + 3'd1;
    end
    deflSum   = {1'b0, deflCnt_q} + {14'd0, deflNum};
    deflCnt_d = deflSum[16] ? 16'hFFFF : deflSum[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) deflCnt_q <= '0;
    else        deflCnt_q <= deflCnt_d;
  end

  assign defl_cnt = deflCnt_q;
`else
  assign defl_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_permute_stage.sv
// tb_permute_stage
//   Scoreboard bench for permute_stage at router (2,2). Stimulus pushes the
//   reference model's expected outputs into a queue; a monitor compares them
//   when they fall due two edges later.
module tb_permute_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [10:0] in_n, in_s, in_e, in_w;
  logic iv_n, iv_s, iv_e, iv_w;
  logic [10:0] out_n, out_s, out_e, out_w;
  logic ov_n, ov_s, ov_e, ov_w;
  logic [15:0] defl_cnt;

  permute_stage #(.MY_X(3'd2), .MY_Y(3'd2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_n(in_n), .in_s(in_s), .in_e(in_e), .in_w(in_w),
    .iv_n(iv_n), .iv_s(iv_s), .iv_e(iv_e), .iv_w(iv_w),
    .out_n(out_n), .out_s(out_s), .out_e(out_e), .out_w(out_w),
    .ov_n(ov_n), .ov_s(ov_s), .ov_e(ov_e), .ov_w(ov_w),
    .defl_cnt(defl_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    int due;
    int defl;
    logic [3:0] v;
    logic [3:0][10:0] f;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;
  bit tog [4];
  int modelDefl = 0;

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h exp=%h at cycle %0d", name, got, exp, cyc);
    end
  endtask

  function automatic logic [10:0] mkFlit(bit g, bit s, int age, int x, int y);
    logic [10:0] f;
    f = {g, s, 3'(age), 3'(x), 3'(y)};
    return f;
  endfunction

  // Productive port at (2,2): 0=N 1=S 2=E 3=W.
  function automatic int prodPort(logic [10:0] f);
    int x, y;
    x = int'(f[5:3]);
    y = int'(f[2:0]);
    if (x > 2) return 2;
    if (x < 2) return 3;
    if (y > 2) return 0;
    if (y < 2) return 1;
    return 0;
  endfunction

  function automatic logic [10:0] aged(logic [10:0] f);
    logic [10:0] r;
    int a;
    r = f;
    a = int'(f[8:6]);
    if (a < 7) a = a + 1;
    r[8:6] = 3'(a);
    return r;
  endfunction

  // One 2x2 block: rank = 32 + {golden,silver,age} for valid flits, 0 otherwise.
  task automatic modelBlock(input int blk, input logic [10:0] fa, input bit va,
                            input logic [10:0] fb, input bit vb,
                            output logic [10:0] o0, output logic [10:0] o1,
                            output bit v0, output bit v1);
    int ka, kb, p;
    bit aw, hi, wv, lv;
    logic [10:0] wf, lf;
    ka = va ? 32 + int'(fa[10:6]) : 0;
    kb = vb ? 32 + int'(fb[10:6]) : 0;
    if (va && vb && ka == kb) begin
      aw = !tog[blk];
      tog[blk] = !tog[blk];
    end else begin
      aw = ka > kb;
    end
    wf = aw ? fa : fb;  wv = aw ? va : vb;
    lf = aw ? fb : fa;  lv = aw ? vb : va;
    p = prodPort(wf);
    if (blk < 2)       hi = !(p == 0 || p == 1);
    else if (blk == 2) hi = (p == 1);
    else               hi = (p == 3);
    o0 = hi ? lf : wf;  v0 = hi ? lv : wv;
    o1 = hi ? wf : lf;  v1 = hi ? wv : lv;
  endtask

  task automatic driveNow(input logic [3:0][10:0] f, input logic [3:0] v);
    logic [10:0] a0, a1, b0, b1;
    bit av0, av1, bv0, bv1;
    logic [10:0] o [4];
    bit ov [4];
    exp_t e;
    int nd;
    in_n = f[0]; in_s = f[1]; in_e = f[2]; in_w = f[3];
    iv_n = v[0]; iv_s = v[1]; iv_e = v[2]; iv_w = v[3];
    modelBlock(0, f[0], v[0], f[2], v[2], a0, a1, av0, av1);
    modelBlock(1, f[1], v[1], f[3], v[3], b0, b1, bv0, bv1);
    modelBlock(2, a0, av0, b0, bv0, o[0], o[1], ov[0], ov[1]);
    modelBlock(3, a1, av1, b1, bv1, o[2], o[3], ov[2], ov[3]);
    nd = 0;
    e.due = cyc + 2;
    for (int p = 0; p < 4; p++) begin
      e.v[p] = ov[p];
      e.f[p] = ov[p] ? aged(o[p]) : 11'd0;
      if (ov[p] && prodPort(o[p]) != p) nd++;
    end
    modelDefl = (modelDefl + nd > 65535) ? 65535 : modelDefl + nd;
    e.defl = modelDefl;
    q.push_back(e);
  endtask

  task automatic applyStimulus(input logic [3:0][10:0] f, input logic [3:0] v);
    @(negedge clk);
    driveNow(f, v);
  endtask

  function automatic logic [3:0][10:0] randFlits();
    logic [3:0][10:0] f;
    for (int p = 0; p < 4; p++) f[p] = 11'($urandom);
    return f;
  endfunction

  function automatic logic [3:0][10:0] oneFlit(int port, logic [10:0] x);
    logic [3:0][10:0] f;
    f = '0;
    f[port] = x;
    return f;
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    int expDefl;
    while (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
`ifdef PERM_STATS_EN
      expDefl = e.defl;
`else
      expDefl = 0;
`endif
      checkOutput("flits", 64'({out_w, out_e, out_s, out_n}), 64'(e.f));
      checkOutput("valids", 64'({ov_w, ov_e, ov_s, ov_n}), 64'(e.v));
      checkOutput("defl_cnt", 64'(defl_cnt), 64'(expDefl));
    end
  end

  initial begin : watchdog
    #1ms;
    $display("[TB] FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    logic [10:0] nTie, eTie;
    logic [3:0][10:0] f;
    f = randFlits();
    {in_w, in_e, in_s, in_n} = f;
    {iv_w, iv_e, iv_s, iv_n} = 4'hF;

    // Reset held with all inputs valid: nothing may come out.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_ov", 64'({ov_w, ov_e, ov_s, ov_n}), 64'd0);
    checkOutput("rst_out", 64'({out_w, out_e, out_s, out_n}), 64'd0);
    checkOutput("rst_defl", 64'(defl_cnt), 64'd0);

    @(negedge clk);
    rst_n = 1'b1;
    driveNow(oneFlit(1, mkFlit(0, 0, 1, 2, 0)), 4'b0010);
    @(posedge clk);
    #1;
    checkOutput("rel_first_edge_ov", 64'({ov_w, ov_e, ov_s, ov_n}), 64'd0);
    applyStimulus('0, 4'b0000);

    // Single N flit to (5,2), age 3 -> E, age 4.
    applyStimulus(oneFlit(0, mkFlit(0, 0, 3, 5, 2)), 4'b0001);
    applyStimulus('0, 4'b0000);
    @(posedge clk);
    #1;
    checkOutput("single_out_e", 64'(out_e), 64'(mkFlit(0, 0, 4, 5, 2)));
    checkOutput("single_ov", 64'({ov_w, ov_e, ov_s, ov_n}), 64'(4'b0100));

    // Golden N beats non-golden E for port E; E flit deflected to N.
    f = '0;
    f[0] = mkFlit(1, 0, 0, 5, 2);
    f[2] = mkFlit(0, 0, 0, 5, 2);
    applyStimulus(f, 4'b0101);
    applyStimulus('0, 4'b0000);
    @(posedge clk);
    #1;
    checkOutput("golden_out_e", 64'(out_e), 64'(mkFlit(1, 0, 1, 5, 2)));
    checkOutput("golden_defl_out_n", 64'(out_n), 64'(mkFlit(0, 0, 1, 5, 2)));

    // Full ties on block A: E winner alternates N, E, N, E.
    nTie = mkFlit(0, 0, 2, 5, 1);
    eTie = mkFlit(0, 0, 2, 5, 3);
    for (int i = 0; i < 4; i++) begin
      f = '0;
      f[0] = nTie;
      f[2] = eTie;
      applyStimulus(f, 4'b0101);
      applyStimulus('0, 4'b0000);
      @(posedge clk);
      #1;
      checkOutput("tie_out_e", 64'(out_e), 64'((i % 2 == 0) ? aged(nTie) : aged(eTie)));
    end

    // Age saturation.
    applyStimulus(oneFlit(0, mkFlit(0, 1, 7, 5, 2)), 4'b0001);
    applyStimulus('0, 4'b0000);
    @(posedge clk);
    #1;
    checkOutput("age7_out_e", 64'(out_e), 64'(mkFlit(0, 1, 7, 5, 2)));

    // Full load: all four valid every cycle.
    for (int i = 0; i < 100; i++) applyStimulus(randFlits(), 4'hF);

    // Random traffic with one asynchronous reset in the middle.
    for (int i = 0; i < 10000; i++) begin
      applyStimulus(randFlits(), 4'($urandom));
      if (i == 5000) begin
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_ov", 64'({ov_w, ov_e, ov_s, ov_n}), 64'd0);
        checkOutput("midrst_out", 64'({out_w, out_e, out_s, out_n}), 64'd0);
        checkOutput("midrst_defl", 64'(defl_cnt), 64'd0);
        q.delete();
        for (int b = 0; b < 4; b++) tog[b] = 1'b0;
        modelDefl = 0;
        @(negedge clk);
        rst_n = 1'b1;
        driveNow(randFlits(), 4'hF);
      end
    end

    applyStimulus('0, 4'b0000);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("drain_queue_empty", 64'(q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
